avalon_vjtag_burst_master: RTL
==============================

Name: avalon_vjtag_burst_master

Overview:
- Command-driven Avalon-MM master in the avm_mj_clk domain; next generation of the JTAG debug master.
- Executes single-beat or multi-beat read/write bursts with incrementing or fixed addressing, write data streamed in, read data buffered in a parametrised FIFO.
- Adds waitrequest timeout abort, sticky error and a reset-request pulse.
- The JTAG scan front end drives it through an already-synchronised valid/ready command interface.

Parameters:
- DATA_WIDTH, 32, Avalon data width.
- ADDR_WIDTH, 32, Avalon address width.
- LEN_WIDTH, 8, width of the beat-count field.
- FIFO_DEPTH, 16, read-data FIFO entries; power of 2, >=2.
- ADDR_INC, 4, address increment per beat in incrementing mode.
- TIMEOUT_CYCLES, 1024, consecutive stalled cycles before abort; >=1.

Ports:
- avm_mj_clk  in  1  clock.
- avm_mj_reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_incr  in  1  1=address += ADDR_INC per beat, 0=fixed address.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beat count; 0 = no bus activity.
- wr_valid  in  1  write word available.
- wr_data  in  DATA_WIDTH  write word.
- wr_ready  out  1  write word consumed this cycle.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_WIDTH  FIFO head, show-ahead.
- rd_ready  in  1  pop FIFO.
- reset_cmd  in  1  request a slave reset.
- err_clr  in  1  clear err_timeout.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at command completion.
- err_timeout  out  1  sticky timeout flag.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- avm_mj_address  out  ADDR_WIDTH  current beat address.
- avm_mj_read  out  1  Avalon read.
- avm_mj_write  out  1  Avalon write.
- avm_mj_writedata  out  DATA_WIDTH  equals wr_data while avm_mj_write is high.
- avm_mj_readdata  in  DATA_WIDTH  read data, valid when read && !waitrequest.
- avm_mj_waitrequest  in  1  slave stall.
- avm_mj_resetrequest  out  1  one-cycle reset pulse.

Behaviour:
- Reset (async, any time, including mid-burst): state IDLE.
  - cmd_ready=1; all other outputs 0.
  - FIFO emptied; beat counter, address register and timeout counter cleared.
  - No bus strobe in the first cycle after reset release.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - cmd_valid && cmd_ready latches addr, len, incr.
  - cmd_len==0 -> DONE.
  - Otherwise -> READ or WRITE per cmd_write.
  - Bus strobes start the cycle after acceptance.
- READ:
  - avm_mj_read = !fifo_full (combinational from registered count).
  - A beat completes when read && !waitrequest: readdata pushed, beats_left-1, address += ADDR_INC if incr.
  - Back-to-back beats are allowed.
  - Last beat -> DONE.
  - FIFO push and pop in the same cycle leave the level unchanged.
  - Pop on an empty FIFO is ignored.
- WRITE:
  - avm_mj_write = wr_valid.
  - Beat completes when write && !waitrequest: wr_ready=1 the same cycle, beats_left-1, address update as above.
  - Last beat -> DONE.
  - Address and writedata held stable while waitrequest=1.
- DONE: done=1 for exactly one cycle -> IDLE; cmd_ready=1 the following cycle.
- Timeout:
  - Counter increments only in cycles where (read || write) && waitrequest.
  - Cleared on each completed beat and on command acceptance.
  - Cycles stalled on FIFO full or missing wr_valid are not counted.
  - When the counter reaches TIMEOUT_CYCLES: strobes drop the next cycle, err_timeout=1, remaining beats discarded, -> DONE.
- err_timeout stays set until err_clr. Setting and clearing in the same cycle: set wins.
- A new command is accepted while err_timeout=1.
- reset_cmd: avm_mj_resetrequest pulses 1 cycle, registered, one cycle after each reset_cmd rising edge. Independent of FSM state.
- Beat count and address arithmetic are modulo 2^width; address wrap-around is silent.

Test Plan:
- Single read, cmd_addr=0x1000, len=1, waitrequest=0, readdata=0xDEADBEEF -> read high 1 cycle at 0x1000; rd_data=0xDEADBEEF, fifo_level=1; done pulses; cmd_ready returns next cycle.
- Incr write, addr=0x200, len=4, waitrequest high 2 cycles per beat, wr_data 0x11..0x44 -> addresses 0x200/0x204/0x208/0x20C; writedata stable during stalls; 4 wr_ready pulses; done after the last beat.
- Fixed read, addr=0x40, len=20, FIFO_DEPTH=16, rd_ready=0 -> 16 beats at 0x40; read drops at fifo_level=16, busy stays 1; assert rd_ready -> remaining 4 beats; done.
- TIMEOUT_CYCLES=8, write len=3, waitrequest stuck 1 -> write drops after 8 stalled cycles; err_timeout=1; done pulses with 0 wr_ready; err_clr -> 0.
- Reset asserted during beat 3 of a len=8 read -> strobes 0, fifo_level=0, cmd_ready=1 immediately; new command after release executes normally.
- cmd_len=0 -> done pulse with no strobes; reset_cmd pulse -> avm_mj_resetrequest high exactly 1 cycle.

Source files
------------

// File: rtl/avalon_vjtag_burst_master.sv
// Command-driven Avalon-MM burst master for the virtual-JTAG debug path.
// Read beats land in a show-ahead FIFO; bursts stalled by waitrequest abort after TIMEOUT_CYCLES.
module avalon_vjtag_burst_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_INC       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        avm_mj_clk,
  input  logic                        avm_mj_reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic                        cmd_incr,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr,
  input  logic [LEN_WIDTH-1:0]        cmd_len,
  input  logic                        wr_valid,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_ready,
  output logic                        rd_valid,
  output logic [DATA_WIDTH-1:0]       rd_data,
  input  logic                        rd_ready,
  input  logic                        reset_cmd,
  input  logic                        err_clr,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [ADDR_WIDTH-1:0]       avm_mj_address,
  output logic                        avm_mj_read,
  output logic                        avm_mj_write,
  output logic [DATA_WIDTH-1:0]       avm_mj_writedata,
  input  logic [DATA_WIDTH-1:0]       avm_mj_readdata,
  input  logic                        avm_mj_waitrequest,
  output logic                        avm_mj_resetrequest
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic                  incr_q, incr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rst_cmd_q, rst_cmd_d;
  logic                  rst_req_q, rst_req_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic fifo_full, push, pop, beat_done, stalled, timeout_hit;

  always_comb begin
    fifo_full        = (count_q == CW'(FIFO_DEPTH));
    avm_mj_read      = (state_q == READ) && !fifo_full;
    avm_mj_write     = (state_q == WRITE) && wr_valid;
    avm_mj_writedata = avm_mj_write ? wr_data : '0;
    avm_mj_address   = addr_q;
    beat_done        = (avm_mj_read || avm_mj_write) && !avm_mj_waitrequest;
    stalled          = (avm_mj_read || avm_mj_write) && avm_mj_waitrequest;
    timeout_hit      = stalled && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    wr_ready         = avm_mj_write && !avm_mj_waitrequest;
    push             = avm_mj_read && !avm_mj_waitrequest;
    pop              = rd_ready && (count_q != '0);
    rd_valid         = (count_q != '0);
    rd_data          = rd_valid ? fifo_mem_q[rptr_q] : '0;
    fifo_level       = count_q;
    cmd_ready        = (state_q == IDLE);
    busy             = (state_q != IDLE);
    done             = (state_q == DONE);
    err_timeout      = err_q;
    avm_mj_resetrequest = rst_req_q;
  end

  // Only stalls with a strobe up count toward the timeout; the set of err wins over a same-cycle clear.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    incr_d  = incr_q;
    tmo_d   = tmo_q;
    err_d   = err_clr ? 1'b0 : err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          beats_d = cmd_len;
          incr_d  = cmd_incr;
          tmo_d   = '0;
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      READ, WRITE: begin
        if (beat_done) begin
          tmo_d   = '0;
          beats_d = beats_q - LEN_WIDTH'(1);
          if (incr_q) addr_d = addr_q + ADDR_WIDTH'(ADDR_INC);
          if (beats_q == LEN_WIDTH'(1)) state_d = DONE;
        end else if (timeout_hit) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (stalled) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    rst_cmd_d = reset_cmd;
    rst_req_d = reset_cmd && !rst_cmd_q;
  end

  always_ff @(posedge avm_mj_clk or posedge avm_mj_reset) begin
    if (avm_mj_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      incr_q    <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rst_cmd_q <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
      incr_q    <= incr_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rst_cmd_q <= rst_cmd_d;
      rst_req_q <= rst_req_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge avm_mj_clk) begin
    if (push) fifo_mem_q[wptr_q] <= avm_mj_readdata;
  end

endmodule
